inst_fetch_buffer: RTL and testbench

//  Parametrised circular instruction queue between the fetch stage (pc/if) and decode.

---
 rtl/inst_fetch_buffer_pkg.sv | 9 +
 rtl/ifb_lane_rotator.sv | 25 ++
 rtl/inst_fetch_buffer.sv | 118 +++++++++++
 tb/tb_inst_fetch_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// inst_fetch_buffer_pkg: default geometry shared by the fetch buffer and its users.
package inst_fetch_buffer_pkg;
  localparam int IFB_DEPTH = 8;
  localparam int IFB_FETCH_WIDTH = 2;
  localparam int IFB_ISSUE_WIDTH = 2;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/ifb_lane_rotator.sv
// ifb_lane_rotator: head-aligned DEPTH->ISSUE_WIDTH entry select; lanes at or past count read as zero.
module ifb_lane_rotator #(
  parameter int DEPTH = 8,
  parameter int ISSUE_WIDTH = 2,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic [PW-1:0]                      head_i,
  input  logic [CW-1:0]                      count_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]       pc_i,
  input  logic [DEPTH-1:0][INST_W-1:0]       inst_i,
  output logic [ISSUE_WIDTH-1:0]             valid_o,
  output logic [ISSUE_WIDTH-1:0][ADDR_W-1:0] pc_o,
  output logic [ISSUE_WIDTH-1:0][INST_W-1:0] inst_o
);
  always_comb begin
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      valid_o[j] = count_i > CW'(j);
      pc_o[j] = valid_o[j] ? pc_i[head_i + PW'(j)] : '0;
      inst_o[j] = valid_o[j] ? inst_i[head_i + PW'(j)] : '0;
    end
  end
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: circular fetch->decode instruction queue with pause, clamped pop and flush.
// Define IFB_BYPASS_EN to let an empty queue forward the fetch beat to decode in the same cycle.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH,
  parameter int FETCH_WIDTH = IFB_FETCH_WIDTH,
  parameter int ISSUE_WIDTH = IFB_ISSUE_WIDTH,
  parameter int ADDR_W = INST_ADDR_WIDTH,
  parameter int INST_W = INST_WIDTH,
  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          pause_i,
  input  logic                          fetch_valid_i,
  input  logic [ADDR_W-1:0]             fetch_pc_i,
  input  logic [FETCH_WIDTH*INST_W-1:0] fetch_inst_i,
  input  logic [FETCH_WIDTH-1:0]        fetch_mask_i,
  output logic                          fetch_ready_o,
  output logic [ISSUE_WIDTH-1:0]        decode_valid_o,
  output logic [ISSUE_WIDTH*ADDR_W-1:0] decode_pc_o,
  output logic [ISSUE_WIDTH*INST_W-1:0] decode_inst_o,
  input  logic [CNT_W-1:0]              decode_pop_i,
  output logic [CW-1:0]                 count_o
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, pushed, avail, req, pop_eff, skip;
  logic [DEPTH-1:0][ADDR_W-1:0] pc_q, pc_d;
  logic [DEPTH-1:0][INST_W-1:0] inst_q, inst_d;
  logic byp;
  logic [ISSUE_WIDTH-1:0] rot_valid;
  logic [ISSUE_WIDTH-1:0][ADDR_W-1:0] rot_pc, out_pc;
  logic [ISSUE_WIDTH-1:0][INST_W-1:0] rot_inst, out_inst;

  assign fetch_ready_o = !rst && (CW'(DEPTH) - count_q >= CW'(FETCH_WIDTH));
  assign count_o = count_q;
  assign pushed = (fetch_valid_i && fetch_ready_o) ? CW'($countones(fetch_mask_i)) : '0;

`ifdef IFB_BYPASS_EN
  localparam int LW = ISSUE_WIDTH > FETCH_WIDTH ? ISSUE_WIDTH : FETCH_WIDTH;
  localparam int LBITS = LW * INST_W;
  logic [LW-1:0][INST_W-1:0] lane_inst;
  assign lane_inst = LBITS'(fetch_inst_i);
  assign byp = count_q == '0 && !flush_i && pushed != '0;
`else
  assign byp = 1'b0;
`endif

  // With bypass, lanes consumed straight from fetch are skipped at enqueue and never move head.
  always_comb begin
    avail = byp ? pushed : count_q;
    req = CW'(decode_pop_i);
    pop_eff = pause_i ? '0 : (req > avail ? avail : req);
    skip = byp ? pop_eff : '0;
    pc_d = pc_q;
    inst_d = inst_q;
    for (int k = 0; k < FETCH_WIDTH; k++)
      if (!flush_i && CW'(k) >= skip && CW'(k) < pushed) begin
        pc_d[tail_q + PW'(k) - PW'(skip)] = fetch_pc_i + ADDR_W'(INST_BYTES * k);
        inst_d[tail_q + PW'(k) - PW'(skip)] = fetch_inst_i[k*INST_W +: INST_W];
      end
    head_d = flush_i ? '0 : head_q + PW'(pop_eff - skip);
    tail_d = flush_i ? '0 : tail_q + PW'(pushed - skip);
    count_d = flush_i ? '0 : count_q + pushed - pop_eff;
  end

  always_comb begin
    decode_valid_o = rot_valid;
    out_pc = rot_pc;
    out_inst = rot_inst;
`ifdef IFB_BYPASS_EN
    if (byp)
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        decode_valid_o[j] = pushed > CW'(j);
        out_pc[j] = decode_valid_o[j] ? fetch_pc_i + ADDR_W'(INST_BYTES * j) : '0;
        out_inst[j] = decode_valid_o[j] ? lane_inst[j] : '0;
      end
`endif
    decode_pc_o = out_pc;
    decode_inst_o = out_inst;
  end

  ifb_lane_rotator #(
    .DEPTH(DEPTH),
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .ADDR_W(ADDR_W),
    .INST_W(INST_W)
  ) u_rot (
    .head_i(head_q),
    .count_i(count_q),
    .pc_i(pc_q),
    .inst_i(inst_q),
    .valid_o(rot_valid),
    .pc_o(rot_pc),
    .inst_o(rot_inst)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end

  // Occupancy lives in count, so storage needs no reset.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    inst_q <= inst_d;
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed scenarios plus random traffic against a queue reference model.
module tb_inst_fetch_buffer;
  logic clk = 0, rst = 1;
  logic flush_i = 0, pause_i = 0, fetch_valid_i = 0;
  logic [31:0] fetch_pc_i = '0;
  logic [63:0] fetch_inst_i = '0;
  logic [1:0] fetch_mask_i = '0, decode_pop_i = '0, decode_valid_o;
  logic fetch_ready_o;
  logic [63:0] decode_pc_o, decode_inst_o;
  logic [3:0] count_o;
  int vecs = 0, errs = 0;
  logic [31:0] npc = 32'h1c00_0000;
  logic [63:0] q[$];

  inst_fetch_buffer dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .pause_i(pause_i),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
    .fetch_mask_i(fetch_mask_i), .fetch_ready_o(fetch_ready_o), .decode_valid_o(decode_valid_o),
    .decode_pc_o(decode_pc_o), .decode_inst_o(decode_inst_o), .decode_pop_i(decode_pop_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive, check against the model before the edge, then advance the model.
  task automatic cyc(input bit fv, input logic [31:0] pc, input logic [63:0] inst,
                     input logic [1:0] mask, input logic [1:0] pop, input bit pz, input bit fl);
    int n, pe, sz, av, sk;
    bit rdy, byp, ev;
    logic [63:0] lanes[2], ee;
    fetch_valid_i = fv; fetch_pc_i = pc; fetch_inst_i = inst; fetch_mask_i = mask;
    decode_pop_i = pop; pause_i = pz; flush_i = fl;
    sz = q.size();
    rdy = (8 - sz) >= 2;
    n = (fv && rdy) ? $countones(mask) : 0;
    for (int k = 0; k < 2; k++) lanes[k] = {pc + 32'(4 * k), inst[k*32 +: 32]};
    byp = 0;
`ifdef IFB_BYPASS_EN
    byp = sz == 0 && !fl && n > 0;
`endif
    av = byp ? n : sz;
    pe = pz ? 0 : (int'(pop) < av ? int'(pop) : av);
    sk = byp ? pe : 0;
    @(negedge clk);
    chk("count", 64'(count_o), 64'(sz));
    chk("ready", 64'(fetch_ready_o), 64'(rdy));
    for (int j = 0; j < 2; j++) begin
      ev = j < av;
      ee = !ev ? 64'h0 : byp ? lanes[j] : q[j];
      chk("valid", 64'(decode_valid_o[j]), 64'(ev));
      chk("pc", 64'(decode_pc_o[j*32 +: 32]), 64'(ee[63:32]));
      chk("inst", 64'(decode_inst_o[j*32 +: 32]), 64'(ee[31:0]));
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      repeat (pe - sk) void'(q.pop_front());
      for (int k = sk; k < n; k++) q.push_back(lanes[k]);
    end
    #1;
  endtask

  task automatic push(input logic [1:0] mask, input logic [1:0] pop);
    cyc(1, npc, {$urandom, $urandom}, mask, pop, 0, 0);
    npc += 8;
  endtask

  initial begin
    logic [1:0] m;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_valid", 64'(decode_valid_o), 0);
    chk("rst_ready", 64'(fetch_ready_o), 0);
    chk("rst_pc", decode_pc_o, 0);
    rst = 0;
    cyc(1, 32'h1c00_0000, {32'h0280_0842, 32'h0280_0421}, 2'b11, 0, 0, 0);
    chk("t1_valid", 64'(decode_valid_o), 64'h3);
    chk("t1_pc", decode_pc_o, 64'h1c00_0004_1c00_0000);
    chk("t1_count", 64'(count_o), 2);
    repeat (3) push(2'b11, 0);
    chk("t2_full", 64'(count_o), 8);
    chk("t2_full_rdy", 64'(fetch_ready_o), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("t2_c7", 64'(count_o), 7);
    chk("t2_c7_rdy", 64'(fetch_ready_o), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("t2_c6_rdy", 64'(fetch_ready_o), 1);
    repeat (2) cyc(0, 0, 0, 0, 2, 0, 0);
    repeat (20) push(2'b11, 2);
    chk("t3_count", 64'(count_o), 2);
    push(2'b11, 0);
    push(2'b01, 0);
    chk("t4_c5", 64'(count_o), 5);
    cyc(1, npc, 64'hdead_beef_cafe_f00d, 2'b11, 2, 0, 1);
    chk("t4_count", 64'(count_o), 0);
    chk("t4_valid", 64'(decode_valid_o), 0);
    chk("t4_ready", 64'(fetch_ready_o), 1);
    push(2'b11, 0);
    push(2'b01, 0);
    cyc(0, 0, 0, 0, 2, 1, 0);
    chk("t5_pause", 64'(count_o), 3);
    cyc(0, 0, 0, 0, 2, 0, 0);
    cyc(0, 0, 0, 0, 2, 0, 0);
    chk("t5_clamp", 64'(count_o), 0);
    push(2'b11, 0);
    push(2'b01, 0);
    #2 rst = 1;
    #1;
    chk("t6_count", 64'(count_o), 0);
    chk("t6_valid", 64'(decode_valid_o), 0);
    chk("t6_ready", 64'(fetch_ready_o), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 0;
    push(2'b01, 0);
    chk("t6_push_cnt", 64'(count_o), 1);
    chk("t6_push_valid", 64'(decode_valid_o), 1);
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
      cyc($urandom_range(0, 3) != 0, $urandom, {$urandom, $urandom}, m, 2'($urandom_range(0, 3)),
          $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
